// File: rtl/tt_lut_seq.sv
// Runtime-reprogrammable N_IN-input truth-table block with a registered valid/ready output stage
// and a serial MSB-first table loader that commits a full table atomically.
module tt_lut_seq #(
   parameter int unsigned           N_IN       = 3,
   parameter logic [2**N_IN-1:0]    DEFAULT_TT = 'h50
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_IN-1:0]      in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 cfg_start,
   input  logic                 cfg_valid,
   input  logic                 cfg_bit,
   output logic                 cfg_busy,
   output logic                 cfg_done,
   output logic [2**N_IN-1:0]   tt_active
);

   localparam int unsigned W    = 2 ** N_IN;
   localparam int unsigned CntW = $clog2(W) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

   typedef enum logic {StIdle, StLoad} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    shd_q, shd_d;
   logic [W-1:0]    tt_q, tt_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            out_valid_q, out_valid_d;
   logic            out_data_q, out_data_d;
   logic [N_IN-1:0] tt_idx;
   logic            accept;

   // Input 0 selects the MSB, so the bit index is W-1-in_data, i.e. the bitwise inverse.
   assign tt_idx   = ~in_data;
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = tt_q[tt_idx];
      end else if (out_ready && out_valid_q) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      shd_d   = shd_q;
      tt_d    = tt_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_start) begin
               state_d = StLoad;
               cnt_d   = '0;
               shd_d   = '0;
            end
         end
         StLoad: begin
            // A restart wins over a same-cycle data beat; that beat is dropped.
            if (cfg_start) begin
               cnt_d = '0;
               shd_d = '0;
            end else if (cfg_valid) begin
               if (cnt_q == CntLast) begin
                  tt_d    = {shd_q[W-2:0], cfg_bit};
                  state_d = StIdle;
                  done_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  shd_d = {shd_q[W-2:0], cfg_bit};
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         shd_q       <= '0;
         tt_q        <= DEFAULT_TT;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shd_q       <= shd_d;
         tt_q        <= tt_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign cfg_busy  = (state_q == StLoad);
   assign cfg_done  = done_q;
   assign tt_active = tt_q;

endmodule

// File: tb/tb_tt_lut_seq.sv
// Directed bench for tt_lut_seq (N_IN=3): reset defaults, evaluation, serial loads, restart,
// commit race, backpressure and reset during a load.
module tb_tt_lut_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       cfg_start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_bit = 1'b0;
   logic       cfg_busy;
   logic       cfg_done;
   logic [7:0] tt_active;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   tt_lut_seq #(
      .N_IN       (3),
      .DEFAULT_TT (8'h50)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_bit   (cfg_bit),
      .cfg_busy  (cfg_busy),
      .cfg_done  (cfg_done),
      .tt_active (tt_active)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (cfg_done === 1'b1) done_cnt <= done_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Shifts one configuration bit in on the next edge.
   task automatic cfg_send(input logic b);
      cfg_valid = 1'b1;
      cfg_bit   = b;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic cfg_begin();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic eval_issue(input logic [2:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (tt_active !== 8'h50) begin errors++;
         $display("FAIL reset_tt: got %h expected 50", tt_active); end
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== 1'b0) begin errors++;
         $display("FAIL reset_out_data: got %b expected 0", out_data); end
      checks++; if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin errors++;
         $display("FAIL reset_cfg: got busy=%b done=%b expected 0 0", cfg_busy, cfg_done); end
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_default_eval();
      logic [2:0] vec [4] = '{3'b001, 3'b011, 3'b101, 3'b000};
      logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         eval_issue(vec[i]);
         checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++;
            $display("FAIL default_eval[%0d]: got v=%b d=%b expected v=1 d=%b",
                     i, out_valid, out_data, exp[i]); end
      end
      tick();
   endtask

   task automatic test_load_majority();
      logic [7:0] v = 8'h17;
      logic [2:0] vec [3] = '{3'b011, 3'b100, 3'b111};
      logic       exp [3] = '{1'b1, 1'b0, 1'b1};
      int         d0;
      d0 = done_cnt;
      cfg_begin();
      for (int i = 7; i >= 0; i--) begin
         cfg_send(v[i]);
         if (i == 4) tick();   // gap between beats
      end
      checks++; if (tt_active !== 8'h17 || cfg_done !== 1'b1) begin errors++;
         $display("FAIL maj_commit: got tt=%h done=%b expected tt=17 done=1",
                  tt_active, cfg_done); end
      tick();
      tick();
      checks++; if (done_cnt - d0 !== 1 || cfg_done !== 1'b0) begin errors++;
         $display("FAIL maj_done_pulses: got %0d expected 1", done_cnt - d0); end
      for (int i = 0; i < 3; i++) begin
         eval_issue(vec[i]);
         checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++;
            $display("FAIL maj_eval[%0d]: got v=%b d=%b expected v=1 d=%b",
                     i, out_valid, out_data, exp[i]); end
      end
      tick();
   endtask

   task automatic test_restart();
      logic [4:0] part = 5'b10101;
      int         d0;
      logic       busy_ok = 1'b1;
      d0 = done_cnt;
      cfg_begin();
      for (int i = 4; i >= 0; i--) cfg_send(part[i]);
      checks++; if (cfg_busy !== 1'b1) begin errors++;
         $display("FAIL restart_busy_partial: got %b expected 1", cfg_busy); end
      cfg_start = 1'b1;
      cfg_valid = 1'b1;   // dropped: restart has priority
      cfg_bit   = 1'b0;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (cfg_busy !== 1'b1) busy_ok = 1'b0;
         cfg_send(1'b1);
      end
      checks++; if (busy_ok !== 1'b1) begin errors++;
         $display("FAIL restart_busy_held: got %b expected 1", busy_ok); end
      checks++; if (tt_active !== 8'hFF || cfg_busy !== 1'b0) begin errors++;
         $display("FAIL restart_tt: got tt=%h busy=%b expected FF 0", tt_active, cfg_busy); end
      tick();
      tick();
      checks++; if (done_cnt - d0 !== 1) begin errors++;
         $display("FAIL restart_done_once: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_commit_race();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cfg_begin();
      for (int i = 0; i < 7; i++) cfg_send(1'b0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 3'b001;
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
      tick();
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== 1'b1) begin errors++;
         $display("FAIL race_old_table: got v=%b d=%b expected v=1 d=1", out_valid, out_data); end
      checks++; if (tt_active !== 8'h00) begin errors++;
         $display("FAIL race_tt: got %h expected 00", tt_active); end
      eval_issue(3'b001);
      checks++; if (out_valid !== 1'b1 || out_data !== 1'b0) begin errors++;
         $display("FAIL race_new_table: got v=%b d=%b expected v=1 d=0", out_valid, out_data); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [2:0] vec [3] = '{3'b000, 3'b011, 3'b101};
      logic       exp [3] = '{1'b0, 1'b1, 1'b0};
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 3'b001;
      tick();
      in_data = vec[0];
      for (int k = 0; k < 4; k++) begin
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got rdy=%b v=%b d=%b expected 0 1 1",
                     k, in_ready, out_valid, out_data); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      for (int i = 0; i < 3; i++) begin
         in_data = vec[i];
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin errors++;
            $display("FAIL b2b[%0d]: got v=%b d=%b expected v=1 d=%b",
                     i, out_valid, out_data, exp[i]); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_mid_load();
      int d0;
      out_ready = 1'b0;
      eval_issue(3'b001);   // leave a result pending under backpressure
      cfg_begin();
      for (int i = 0; i < 3; i++) cfg_send(1'b1);
      checks++; if (cfg_busy !== 1'b1 || out_valid !== 1'b1) begin errors++;
         $display("FAIL rml_pre: got busy=%b v=%b expected 1 1", cfg_busy, out_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      checks++; if (tt_active !== 8'h50 || cfg_busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rml_after: got tt=%h busy=%b v=%b expected 50 0 0",
                  tt_active, cfg_busy, out_valid); end
      d0 = done_cnt;
      for (int i = 0; i < 8; i++) cfg_send(1'b1);
      tick();
      checks++; if (tt_active !== 8'h50 || cfg_busy !== 1'b0 || done_cnt - d0 !== 0) begin
         errors++;
         $display("FAIL rml_ignored: got tt=%h busy=%b dones=%0d expected 50 0 0",
                  tt_active, cfg_busy, done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_default_eval();
      test_load_majority();
      test_restart();
      test_commit_race();
      test_back_to_back();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tt_lut_seq.md
# tt_lut_seq

Sequential, parametrised truth-table logic block: an N_IN-input Boolean function whose truth table is held in a register and can be reprogrammed at runtime over a serial configuration port. Evaluations flow through a valid/ready handshake with one registered output stage. It sits where fixed-function hex-named logic modules sit in the logic-synthesis flow. It lets the bench and the gate-assignment tooling sweep many truth tables on one instance without re-elaborating.

## Interface
- N_IN, 3, number of logic inputs; legal range 1..6; W = 2**N_IN is the table width.
- DEFAULT_TT, 8'h50 (W bits), table loaded at reset; same hex naming as the fixed-function logic modules.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_IN  input vector; in_data[N_IN-1] is the first logic input (in1).
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  1  function result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- cfg_start  input  1  begin (or restart) a table load.
- cfg_valid  input  1  cfg_bit valid.
- cfg_bit  input  1  serial table bit, MSB first.
- cfg_busy  output  1  load in progress.
- cfg_done  output  1  one-cycle pulse: new table committed.
- tt_active  output  W  table currently used for evaluation.

## Operation
- Table convention: for input value i = in_data, the result is tt_active[W-1-i]. Input 0 maps to the MSB, matching the hex names of the fixed-function modules.
- Eval path:
  - in_ready = !out_valid || out_ready (combinational).
  - On in_valid && in_ready: out_data <= tt_active[W-1-in_data] and out_valid <= 1.
  - Otherwise, on out_ready && out_valid: out_valid <= 0.
  - out_data holds stable while out_valid && !out_ready.
- Config FSM, states IDLE and LOAD, with a shadow register shd[W-1:0] and a counter cnt of clog2(W)+1 bits.
  - IDLE: cfg_start -> LOAD, cnt <= 0. cfg_valid is ignored.
  - LOAD, cfg_start: restart with cnt <= 0 and the partial shadow discarded. This takes priority over a same-cycle cfg_valid, whose bit is dropped.
  - LOAD, cfg_valid && cnt < W-1: shd <= {shd[W-2:0], cfg_bit}, cnt <= cnt+1.
  - LOAD, cfg_valid && cnt == W-1: tt_active <= {shd[W-2:0], cfg_bit}, go to IDLE, cfg_done <= 1.
  - cfg_busy = (state == LOAD).
- Evaluations continue during LOAD using the old tt_active; there is no stall.

## Timing
- Reset values:
  - tt_active = DEFAULT_TT; out_valid = 0; out_data = 0; cfg_busy = 0; cfg_done = 0; state IDLE; cnt = 0; shd = 0.
  - in_ready = 1 from the first cycle after reset.
- Eval latency is 1 cycle, from the accepting edge to out_valid high.
- Throughput is 1 result/cycle while out_ready = 1.
- Table commit happens on the edge that accepts the W-th bit. An evaluation accepted on that same edge uses the old table; an evaluation accepted on the next edge uses the new one.
- cfg_done is high exactly in the cycle after the commit edge.
- A full load takes W accepted cfg_valid beats after cfg_start, with gaps allowed.
- rst mid-load aborts the load: tt_active returns to DEFAULT_TT and the partial shadow is lost.
- rst while out_valid && !out_ready drops the pending result.
- N_IN = 1 (W = 2): the counter and shift still work; the commit happens on the 2nd bit.

## Test plan
- Reset defaults, N_IN=3: check tt_active = 8'h50. Then evaluate with out_ready=1:
  - in_data 3'b001 -> out_data 1, one cycle later.
  - 3'b011 -> 1.
  - 3'b101 -> 0.
  - 3'b000 -> 0.
- Load 8'h17, majority function (bits 0,0,0,1,0,1,1,1 MSB first):
  - cfg_done pulses once, and tt_active = 8'h17.
  - Then 3'b011 -> 1, 3'b100 -> 0, 3'b111 -> 1.
- Abort/restart: send 5 bits, then assert cfg_start, then load 8'hFF.
  - tt_active = 8'hFF.
  - cfg_busy stays high through the restart.
  - cfg_done pulses exactly once.
- Commit race: accept an eval of 3'b001 on the same edge as the 8th bit of 8'h00.
  - That result is 1 (old table 8'h50).
  - The next eval of 3'b001 gives 0.
- Backpressure:
  - Hold out_ready=0 for 4 cycles with in_valid=1. in_ready must stay 0 after the first accept, and out_data must remain stable.
  - Release out_ready: results arrive back-to-back with no loss or duplication.
- Reset mid-load: after 3 bits, pulse rst.
  - tt_active = 8'h50, cfg_busy = 0, out_valid = 0.
  - A subsequent cfg_valid without cfg_start is ignored.
